// File: rtl/port_egress_buffer_if.sv
// Core-side word stream and MAC-side byte handshake for one egress port buffer.
interface port_egress_buffer_if;
  logic [8:0] core_transmit_data;
  logic       core_transmit_data_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;

  // Buffer side: consumes the core stream, drives the MAC byte stream.
  modport slave (
    input  core_transmit_data,
    input  core_transmit_data_valid,
    input  tx_ready,
    output tx_data,
    output tx_valid,
    output tx_last
  );

  // Environment side: core plus MAC.
  modport master (
    output core_transmit_data,
    output core_transmit_data_valid,
    output tx_ready,
    input  tx_data,
    input  tx_valid,
    input  tx_last
  );
endinterface

// File: rtl/port_egress_buffer.sv
// Per-port egress store-and-forward buffer: captures frames from the core's broadcast bus,
// commits only complete frames and replays them to the MAC. Frames that overflow are
// discarded whole because the core cannot be stalled.
module port_egress_buffer #(
  parameter int unsigned DEPTH      = 2048,
  parameter logic [15:0] IDLE_LIMIT = 16'h000F
) (
  input  logic                     clock,
  input  logic                     reset_n,
  port_egress_buffer_if.slave      bus,
  output logic                     frame_dropped,
  output logic [15:0]              drop_count,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;

  typedef enum logic [1:0] {StIdle, StFrame, StDrop} wr_state_e;

  wr_state_e   state_q, state_d;
  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  ptr_t        frame_start_q, frame_start_d;
  ptr_t        committed_q, committed_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic        frame_dropped_q;
  logic [15:0] drop_count_q;

  logic [7:0]  data_mem [DEPTH];
  logic        last_mem [DEPTH];

  logic          start;
  logic          full;
  logic          wr_en;
  logic          close;
  logic          drop;
  logic          handshake;
  logic          rd_done;
  logic [AW-1:0] close_addr;

  assign start      = bus.core_transmit_data[8];
  assign fifo_level = wr_ptr_q - rd_ptr_q;
  assign full       = (fifo_level == ptr_t'(DEPTH));
  // The last word of the open frame sits just behind the write pointer.
  assign close_addr = wr_ptr_q[AW-1:0] - 1'b1;

  // Read side presents the head entry combinationally whenever a whole frame is committed.
  assign bus.tx_valid = (committed_q != '0);
  assign bus.tx_data  = bus.tx_valid ? data_mem[rd_ptr_q[AW-1:0]] : 8'h00;
  assign bus.tx_last  = bus.tx_valid & last_mem[rd_ptr_q[AW-1:0]];
  assign handshake    = bus.tx_valid & bus.tx_ready;
  assign rd_done      = handshake & bus.tx_last;

  assign frame_dropped = frame_dropped_q;
  assign drop_count    = drop_count_q;

  // Write FSM: frame delimiting, overflow rewind and idle-gap close.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    frame_start_d = frame_start_q;
    idle_cnt_d    = idle_cnt_q;
    wr_en         = 1'b0;
    close         = 1'b0;
    drop          = 1'b0;
    if (bus.core_transmit_data_valid) begin
      idle_cnt_d = '0;
      if (start) begin
        // A start word closes any open frame and opens the next in the same cycle.
        close = (state_q == StFrame);
        if (!full) begin
          wr_en         = 1'b1;
          frame_start_d = wr_ptr_q;
          wr_ptr_d      = wr_ptr_q + 1'b1;
          state_d       = StFrame;
        end else begin
          drop    = 1'b1;
          state_d = StDrop;
        end
      end else if (state_q == StFrame) begin
        if (!full) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
        end else begin
          // Give back only the space of the frame being discarded.
          wr_ptr_d = frame_start_q;
          drop     = 1'b1;
          state_d  = StDrop;
        end
      end
    end else if (state_q != StIdle) begin
      idle_cnt_d = idle_cnt_q + 16'd1;
      if (idle_cnt_d == IDLE_LIMIT) begin
        close   = (state_q == StFrame);
        state_d = StIdle;
      end
    end
  end

  // Committed-frame count: commit and final-byte handshake in one cycle cancel out.
  always_comb begin
    committed_d = committed_q;
    rd_ptr_d    = rd_ptr_q + ptr_t'(handshake);
    if (close && !rd_done) begin
      committed_d = committed_q + 1'b1;
    end else if (!close && rd_done) begin
      committed_d = committed_q - 1'b1;
    end
  end

  // State, pointers and drop statistics.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= StIdle;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      frame_start_q   <= '0;
      committed_q     <= '0;
      idle_cnt_q      <= '0;
      frame_dropped_q <= 1'b0;
      drop_count_q    <= '0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      frame_start_q   <= frame_start_d;
      committed_q     <= committed_d;
      idle_cnt_q      <= idle_cnt_d;
      frame_dropped_q <= drop;
      if (drop && (drop_count_q != 16'hFFFF)) begin
        drop_count_q <= drop_count_q + 16'd1;
      end
    end
  end

  // Storage: a written entry starts with its last flag clear; closing marks the frame's tail.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      data_mem[wr_ptr_q[AW-1:0]] <= bus.core_transmit_data[7:0];
      last_mem[wr_ptr_q[AW-1:0]] <= 1'b0;
    end
    if (close) begin
      last_mem[close_addr] <= 1'b1;
    end
  end

endmodule

// File: doc/port_egress_buffer.md
# port_egress_buffer

Per-port egress store-and-forward buffer sitting between the switch core's shared transmit bus and one physical port's transmit MAC. Captures the 9-bit word stream the core broadcasts with a per-port valid bit, and delimits frames by the start marker (bit 8) and by an idle gap. Commits only complete frames and replays them to the MAC over a valid/ready byte interface with an explicit last flag. The core has no backpressure, so frames that overflow the buffer are discarded whole and counted.

## Interface
- DEPTH, 2048, buffer entries (power of two, ≥16)
- IDLE_LIMIT, 16'h000F, consecutive idle cycles that close an open frame

- clock  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- core_transmit_data  input  9  bit 8 = start-of-frame marker, [7:0] = byte
- core_transmit_data_valid  input  1  this port's valid bit from the core; no ready exists
- tx_data  output  8  byte to MAC
- tx_valid  output  1  tx_data/tx_last valid
- tx_last  output  1  final byte of frame
- tx_ready  input  1  MAC accepts on tx_valid && tx_ready
- frame_dropped  output  1  one-cycle pulse per discarded frame
- drop_count  output  16  saturating count of discarded frames
- fifo_level  output  $clog2(DEPTH)+1  occupied entries (committed + in-progress)

## Operation
- Storage: DEPTH×8 data RAM plus DEPTH×1 last-flag array; wr_ptr/rd_ptr carry one extra wrap bit; full = level == DEPTH.
- Write FSM:
  - W_IDLE: words without bit 8 discarded. Start word: if not full, write at wr_ptr, latch frame_start = wr_ptr, clear idle counter -> W_FRAME; if full, pulse drop -> W_DROP.
  - W_FRAME: valid non-start word written if not full; if full, rewind wr_ptr to frame_start, pulse drop -> W_DROP. Valid start word: close current frame (set last flag at wr_ptr-1, committed_frames+1) and begin new frame in the same cycle (same full rule). Idle cycle increments idle counter; counter reaching IDLE_LIMIT closes frame -> W_IDLE. Any valid clears counter.
  - W_DROP: non-start words ignored; start word handled as in W_IDLE; IDLE_LIMIT idle cycles -> W_IDLE.
- Drop: frame_dropped pulses the cycle after the triggering word; drop_count increments, holds at 16'hFFFF.
- Read side: streams only when committed_frames > 0. Words of a committed frame presented in order; tx_last = stored flag. Handshake on last word decrements committed_frames. Commit and decrement in same cycle net to zero.
- Output holds tx_data/tx_last stable while tx_valid && !tx_ready.

## Timing
- Reset: tx_data 0, tx_valid 0, tx_last 0, frame_dropped 0, drop_count 0, fifo_level 0; pointers 0, committed_frames 0, W_IDLE; mid-frame reset discards everything.
- Write latency: fifo_level reflects a written word the next cycle; rewind reflects the next cycle.
- Commit-to-output: tx_valid asserts ≤2 cycles after committed_frames becomes nonzero.
- Throughput: one byte per cycle within and across committed frames with tx_ready held high; no bubbles.
- Rewind frees space only of the dropped in-progress frame; committed frames never touched.
- Pointer wrap at DEPTH transparent; frame may span wrap.
- Reads free entries the cycle after handshake; a write in that cycle sees the pre-read level (conservative).

## Test plan
- Single frame: start 0x1AA then 0x011..0x01B (12 words), idle 15 cycles, tx_ready=1 -> 12 bytes 0xAA,0x11..0x1B, tx_last only on 0x1B, fifo_level returns 0.
- Back-to-back: frame A (12 words) immediately followed by start word of frame B, no gap -> A emitted with tx_last on its 12th byte, B follows without bubble after B closes.
- Backpressure: tx_ready toggles 1,0,0,1 repeatedly -> every byte emitted exactly once in order, data stable while stalled.
- Overflow: DEPTH=16, tx_ready=0, 10-word frame committed, then 10-word frame -> second dropped, frame_dropped pulses once, drop_count=1, fifo_level=10, first frame later emitted intact.
- Idle close only: frame with 14 idle cycles then continuation word -> stays one frame; 15 idle cycles -> closes, later non-start words discarded.
- Reset mid-frame: assert reset_n low during W_FRAME and during tx output -> all outputs 0 immediately; next frame after release emitted correctly.
